// File: rtl/usb_rx_packet.sv
// USB packet receiver: hunts for SYNC, checks the PID, deserialises payload bytes
// LSB-first and verifies the CRC16 residue, reporting per-packet status flags.
module usb_rx_packet #(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       eop,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic [7:0] data_byte,
    output logic       data_valid,
    output logic [6:0] data_len,
    output logic       pkt_done,
    output logic       crc_ok,
    output logic       pid_err,
    output logic       align_err,
    output logic       len_err
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PID  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'hA001;
    localparam logic [15:0] CRC_RESIDUE = 16'hB001;
    localparam logic [6:0]  MAX_LEN     = 7'(MAX_BYTES);

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    function automatic logic pid_check(input logic [7:0] b);
        return (b[3:0] == ~b[7:4]);
    endfunction

    state_t      state_r, state_s;
    logic [6:0]  window_r, window_s;
    logic [3:0]  fill_r, fill_s;
    logic [6:0]  shift_r, shift_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic [15:0] crc_r, crc_s;
    logic [7:0]  buf0_r, buf0_s;
    logic [7:0]  buf1_r, buf1_s;
    logic [1:0]  buf_cnt_r, buf_cnt_s;
    logic [3:0]  pid_r, pid_s;
    logic        pid_valid_r, pid_valid_s;
    logic [7:0]  data_byte_r, data_byte_s;
    logic        data_valid_r, data_valid_s;
    logic [6:0]  data_len_r, data_len_s;
    logic        pkt_done_r, pkt_done_s;
    logic        crc_ok_r, crc_ok_s;
    logic        pid_err_r, pid_err_s;
    logic        align_err_r, align_err_s;
    logic        len_err_r, len_err_s;
    logic [7:0]  byte_s;
    logic [7:0]  hunt_s;
    logic        take_s;

    // Next-state and next-output logic for the receive FSM
    always_comb begin
        state_s      = state_r;
        window_s     = window_r;
        fill_s       = fill_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        crc_s        = crc_r;
        buf0_s       = buf0_r;
        buf1_s       = buf1_r;
        buf_cnt_s    = buf_cnt_r;
        pid_s        = pid_r;
        pid_valid_s  = 1'b0;
        data_byte_s  = data_byte_r;
        data_valid_s = 1'b0;
        data_len_s   = data_len_r;
        pkt_done_s   = 1'b0;
        crc_ok_s     = crc_ok_r;
        pid_err_s    = pid_err_r;
        align_err_s  = align_err_r;
        len_err_s    = len_err_r;
        byte_s       = {bit_in, shift_r};
        // The SYNC window is the 7 stored bits plus the bit arriving now
        hunt_s       = {bit_in, window_r};
        take_s       = bit_valid & ~eop;

        case (state_r)
            HUNT: begin
                if (take_s) begin
                    window_s = hunt_s[7:1];
                    // fill_r guards against matching on stale or reset window contents
                    if ((fill_r >= 4'd7) && (hunt_s == SYNC_BYTE)) begin
                        state_s     = PID;
                        fill_s      = 4'd0;
                        bit_cnt_s   = 3'd0;
                        data_len_s  = 7'd0;
                        crc_ok_s    = 1'b0;
                        pid_err_s   = 1'b0;
                        align_err_s = 1'b0;
                        len_err_s   = 1'b0;
                    end else if (fill_r < 4'd8) begin
                        fill_s = fill_r + 4'd1;
                    end else begin
                        fill_s = fill_r;
                    end
                end else begin
                    window_s = window_r;
                end
            end
            PID: begin
                if (eop) begin
                    pid_err_s  = 1'b1;
                    pkt_done_s = 1'b1;
                    state_s    = HUNT;
                    fill_s     = 4'd0;
                end else if (bit_valid) begin
                    shift_s   = byte_s[7:1];
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        if (pid_check(byte_s)) begin
                            pid_s       = byte_s[3:0];
                            pid_valid_s = 1'b1;
                            state_s     = DATA;
                            crc_s       = CRC_INIT;
                            buf_cnt_s   = 2'd0;
                        end else begin
                            pid_err_s  = 1'b1;
                            pkt_done_s = 1'b1;
                            state_s    = HUNT;
                            fill_s     = 4'd0;
                        end
                    end else begin
                        state_s = PID;
                    end
                end else begin
                    state_s = PID;
                end
            end
            DATA: begin
                if (eop) begin
                    pkt_done_s = 1'b1;
                    state_s    = HUNT;
                    fill_s     = 4'd0;
                    buf_cnt_s  = 2'd0;
                    if (bit_cnt_r != 3'd0) begin
                        align_err_s = 1'b1;
                        crc_ok_s    = 1'b0;
                    end else begin
                        case (buf_cnt_r)
                            2'd0: crc_ok_s = 1'b1;
                            2'd1: begin
                                crc_ok_s    = 1'b0;
                                align_err_s = 1'b1;
                            end
                            default: crc_ok_s = (crc_r == CRC_RESIDUE);
                        endcase
                    end
                end else if (bit_valid) begin
                    crc_s     = crc16_step(crc_r, bit_in);
                    shift_s   = byte_s[7:1];
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        // Two-byte delay keeps the trailing CRC bytes from being emitted
                        case (buf_cnt_r)
                            2'd0: begin
                                buf0_s    = byte_s;
                                buf_cnt_s = 2'd1;
                            end
                            2'd1: begin
                                buf1_s    = byte_s;
                                buf_cnt_s = 2'd2;
                            end
                            default: begin
                                buf0_s = buf1_r;
                                buf1_s = byte_s;
                                if (!len_err_r && (data_len_r < MAX_LEN)) begin
                                    data_byte_s  = buf0_r;
                                    data_valid_s = 1'b1;
                                    data_len_s   = data_len_r + 7'd1;
                                end else begin
                                    len_err_s = 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            default: begin
                state_s = HUNT;
                fill_s  = 4'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            window_r     <= 7'd0;
            fill_r       <= 4'd0;
            shift_r      <= 7'd0;
            bit_cnt_r    <= 3'd0;
            crc_r        <= 16'h0000;
            buf0_r       <= 8'h00;
            buf1_r       <= 8'h00;
            buf_cnt_r    <= 2'd0;
            pid_r        <= 4'h0;
            pid_valid_r  <= 1'b0;
            data_byte_r  <= 8'h00;
            data_valid_r <= 1'b0;
            data_len_r   <= 7'd0;
            pkt_done_r   <= 1'b0;
            crc_ok_r     <= 1'b0;
            pid_err_r    <= 1'b0;
            align_err_r  <= 1'b0;
            len_err_r    <= 1'b0;
        end else begin
            window_r     <= window_s;
            fill_r       <= fill_s;
            shift_r      <= shift_s;
            bit_cnt_r    <= bit_cnt_s;
            crc_r        <= crc_s;
            buf0_r       <= buf0_s;
            buf1_r       <= buf1_s;
            buf_cnt_r    <= buf_cnt_s;
            pid_r        <= pid_s;
            pid_valid_r  <= pid_valid_s;
            data_byte_r  <= data_byte_s;
            data_valid_r <= data_valid_s;
            data_len_r   <= data_len_s;
            pkt_done_r   <= pkt_done_s;
            crc_ok_r     <= crc_ok_s;
            pid_err_r    <= pid_err_s;
            align_err_r  <= align_err_s;
            len_err_r    <= len_err_s;
        end
    end

    assign pid        = pid_r;
    assign pid_valid  = pid_valid_r;
    assign data_byte  = data_byte_r;
    assign data_valid = data_valid_r;
    assign data_len   = data_len_r;
    assign pkt_done   = pkt_done_r;
    assign crc_ok     = crc_ok_r;
    assign pid_err    = pid_err_r;
    assign align_err  = align_err_r;
    assign len_err    = len_err_r;

endmodule
